boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Bring-up control stage sitting directly upstream of the platform status register and the CPU/SCP RAM pair. It holds the CPU in reset until the SCP reports ready, releases it after a fixed hold window, then watches CPU status writes and resolves the run into PASS, FAIL or TIMEOUT. It drives the 32-bit `status` word that the bring-up bench checks for 0xA5A5A5A5 or 0xDEADBEEF.

## Interface
Parameters:
- `HOLD_CYCLES`, 16, cycles `cpu_rst` stays high after `scp_ready` is seen (≥1)
- `TIMEOUT_CYCLES`, 100000, RUN-state cycle budget before TIMEOUT (≥2)
- `PASS_CODE`, 32'hA5A5A5A5, status value meaning pass
- `FAIL_CODE`, 32'hDEADBEEF, status value meaning fail

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `scp_ready`  in  1  SCP boot complete, level
- `status_we`  in  1  CPU status write strobe, one cycle per write
- `status_wdata`  in  32  CPU status write data
- `cpu_rst`  out  1  active-high reset to CPU core
- `status`  out  32  current status word
- `progress_cnt`  out  8  count of non-terminal status writes, saturating at 255
- `done`  out  1  run resolved (PASS, FAIL or TIMEOUT)
- `pass`  out  1  resolved as pass
- `fail`  out  1  resolved as fail
- `timeout`  out  1  resolved by timeout
- `state`  out  3  FSM state encoding, for debug

## Operation
- States: IDLE=0, WAIT_SCP=1, HOLD=2, RUN=3, PASS=4, FAIL=5, TMO=6.
- Reset values: state=IDLE, `cpu_rst`=1, `status`=0, `progress_cnt`=0, `done`/`pass`/`fail`/`timeout`=0, all counters 0.
- IDLE → WAIT_SCP unconditionally on the next cycle.
- WAIT_SCP: wait for `scp_ready`=1 → HOLD, hold counter cleared.
- HOLD: count HOLD_CYCLES cycles, then → RUN. `scp_ready` dropping during HOLD is ignored.
- RUN: `cpu_rst`=0; timer increments every cycle from 0.
  - Write of PASS_CODE → PASS.
  - Write of FAIL_CODE → FAIL.
  - Any other write → `status` updated, `progress_cnt`+1 (saturating), stay in RUN.
  - Timer reaching TIMEOUT_CYCLES-1 with no terminal write → TMO.
- Every accepted write (terminal or not) loads `status_wdata` into `status`.
- PASS, FAIL and TMO are terminal and hold until `rst`.
  - PASS: `cpu_rst` stays 0.
  - FAIL and TMO: `cpu_rst`=1.
  - TMO leaves `status` at the last written value.
- `status_we` outside RUN is ignored: no `status` or `progress_cnt` change.
- Simultaneous events: a terminal write in the same cycle as timer expiry takes precedence, so the result is PASS or FAIL.
- Flags are one-hot among `pass`/`fail`/`timeout`; `done` is their OR.

## Timing
- All outputs registered.
- `cpu_rst` falls exactly HOLD_CYCLES+1 cycles after the first cycle `scp_ready` is sampled high.
- A write accepted at edge N appears on `status`, and on `done`/`pass`/`fail` if terminal, after edge N (visible in cycle N+1).
- TMO flags rise TIMEOUT_CYCLES cycles after RUN entry.
- `rst` mid-operation returns everything to reset values at the next edge, asserts `cpu_rst`, and aborts any pending write.

## Configuration
- `BOOT_SEQ_HEARTBEAT_EN` defined: every non-terminal write in RUN reloads the timer to 0, so TIMEOUT_CYCLES bounds the gap between writes.
- Not defined: the timer is absolute from RUN entry and writes never reload it.

## Test plan
- Reset, `scp_ready`=1 at cycle 5, HOLD_CYCLES=16 → `cpu_rst` falls at cycle 22; state walks 0→1→2→3.
- In RUN, write 0x00000001 then 0xA5A5A5A5 → `progress_cnt`=1, `status`=0xA5A5A5A5, `pass`=`done`=1, `cpu_rst` stays 0, later writes ignored.
- In RUN, write 0xDEADBEEF → `fail`=1, `cpu_rst`=1, `status`=0xDEADBEEF.
- TIMEOUT_CYCLES=50, no writes → `timeout`=1 exactly 50 cycles after RUN entry, `status`=0.
- TIMEOUT_CYCLES=50, write 0x2 every 40 cycles:
  - with `BOOT_SEQ_HEARTBEAT_EN` → no timeout over 500 cycles;
  - without it → timeout at cycle 50.
- Write PASS_CODE on the expiry cycle → `pass`=1, `timeout`=0. Assert `rst` mid-RUN → all outputs return to reset values one cycle later.

Source files
------------

// File: rtl/boot_sequencer.sv
// boot_sequencer
//   Bring-up control stage. Holds the CPU in reset until the SCP reports
//   ready, releases it after a fixed hold window, then watches CPU status
//   writes and resolves the run into PASS, FAIL or TIMEOUT.
//
//   Optional feature (compile-time macro): BOOT_SEQ_HEARTBEAT_EN
//     defined     : every non-terminal write in RUN reloads the run timer,
//                   so TIMEOUT_CYCLES bounds the gap between writes.
//     not defined : the run timer is absolute from RUN entry.
//
//   Ports
//     clk           system clock
//     rst           synchronous active-high reset
//     scp_ready     SCP boot complete (level)
//     status_we     CPU status write strobe (one cycle per write)
//     status_wdata  CPU status write data
//     cpu_rst       active-high reset to the CPU core
//     status        current status word (last accepted write)
//     progress_cnt  non-terminal writes seen in RUN, saturating at 255
//     done          run resolved (pass | fail | timeout)
//     pass/fail/timeout  one-hot resolution flags
//     state         FSM state encoding, for debug
module boot_sequencer #(
   parameter int          HOLD_CYCLES    = 16,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [31:0] PASS_CODE      = 32'hA5A5A5A5,
   parameter logic [31:0] FAIL_CODE      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scp_ready,
   input  logic        status_we,
   input  logic [31:0] status_wdata,
   output logic        cpu_rst,
   output logic [31:0] status,
   output logic [7:0]  progress_cnt,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [2:0]  state
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_SCP = 3'd1,
      S_HOLD     = 3'd2,
      S_RUN      = 3'd3,
      S_PASS     = 3'd4,
      S_FAIL     = 3'd5,
      S_TMO      = 3'd6
   } state_t;

   state_t          state_q, state_n;
   logic [HW-1:0]   hold_q, hold_n;
   logic [TW-1:0]   timer_q, timer_n;
   logic [31:0]     status_n;
   logic [7:0]      prog_n;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Next-state / next-value logic
   always_comb begin
      state_n  = state_q;
      hold_n   = hold_q;
      timer_n  = timer_q;
      status_n = status;
      prog_n   = progress_cnt;
      case (state_q)
         S_IDLE: state_n = S_WAIT_SCP;
         S_WAIT_SCP: begin
            if (scp_ready) begin
               state_n = S_HOLD;
               hold_n  = '0;
            end
         end
         S_HOLD: begin
            // The cycle the counter reaches HOLD_CYCLES is the last held
            // cycle, so cpu_rst drops HOLD_CYCLES+1 edges after scp_ready.
            if (hold_q == HW'(HOLD_CYCLES)) begin
               state_n = S_RUN;
               timer_n = '0;
            end else begin
               hold_n = hold_q + HW'(1);
            end
         end
         S_RUN: begin
            timer_n = timer_q + TW'(1);
            if (status_we) begin
               status_n = status_wdata;
               if (status_wdata == PASS_CODE) begin
                  state_n = S_PASS;
               end else if (status_wdata == FAIL_CODE) begin
                  state_n = S_FAIL;
               end else begin
                  prog_n = sat_inc8(progress_cnt);
`ifdef BOOT_SEQ_HEARTBEAT_EN
                  timer_n = '0;
`endif
               end
            end
            // A terminal write on the expiry cycle wins over the timeout.
            if (state_n == S_RUN && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n = S_TMO;
            end
         end
         default: ;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         timer_q      <= '0;
         status       <= '0;
         progress_cnt <= '0;
         cpu_rst      <= 1'b1;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state_q      <= state_n;
         hold_q       <= hold_n;
         timer_q      <= timer_n;
         status       <= status_n;
         progress_cnt <= prog_n;
         cpu_rst      <= !(state_n == S_RUN || state_n == S_PASS);
         done         <= (state_n == S_PASS) || (state_n == S_FAIL) || (state_n == S_TMO);
         pass         <= (state_n == S_PASS);
         fail         <= (state_n == S_FAIL);
         timeout      <= (state_n == S_TMO);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer: directed bring-up scenarios plus randomized
// runs, checked cycle by cycle through a scoreboard fed by an event-time
// reference model.
module tb_boot_sequencer;

   localparam int          H  = 16;
   localparam int          T  = 50;
   localparam logic [31:0] PC = 32'hA5A5A5A5;
   localparam logic [31:0] FC = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scp_ready = 1'b0;
   logic        status_we = 1'b0;
   logic [31:0] status_wdata = '0;
   logic        cpu_rst;
   logic [31:0] status;
   logic [7:0]  progress_cnt;
   logic        done, pass, fail, timeout;
   logic [2:0]  state;

   always #5 clk = ~clk;

   boot_sequencer #(
      .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .PASS_CODE(PC), .FAIL_CODE(FC)
   ) dut (
      .clk(clk), .rst(rst), .scp_ready(scp_ready), .status_we(status_we),
      .status_wdata(status_wdata), .cpu_rst(cpu_rst), .status(status),
      .progress_cnt(progress_cnt), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .state(state)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic        cpu_rst;
      logic [31:0] status;
      logic [7:0]  prog;
      logic        done;
      logic        pass;
      logic        fail;
      logic        tmo;
   } snap_t;

   snap_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;

   // Reference model: the run is described by the edge numbers at which
   // things happened (scp seen, RUN entered, last timer base) and the result.
   int          m_n, m_s, m_run, m_base, m_res;
   bit          m_idle_done;
   logic [31:0] m_status;
   int          m_prog;

   function automatic int m_phase();
      if (m_res != 0)   return m_res;
      if (m_run >= 0)   return 3;
      if (m_s >= 0)     return 2;
      return m_idle_done ? 1 : 0;
   endfunction

   task automatic model_edge(input bit r, input bit scp, input bit we, input logic [31:0] wd);
      int    p;
      bit    expired;
      snap_t e;
      m_n++;
      if (r) begin
         m_n = 0; m_s = -1; m_run = -1; m_base = 0; m_res = 0;
         m_idle_done = 0; m_status = '0; m_prog = 0;
      end else begin
         p = m_phase();
         case (p)
            0: m_idle_done = 1;
            1: if (scp) m_s = m_n;
            2: if (m_n == m_s + H + 1) begin m_run = m_n; m_base = m_n; end
            3: begin
               expired = (m_n - m_base == T);
               if (we) begin
                  m_status = wd;
                  if (wd == PC)      m_res = 4;
                  else if (wd == FC) m_res = 5;
                  else begin
                     if (m_prog < 255) m_prog++;
`ifdef BOOT_SEQ_HEARTBEAT_EN
                     m_base = m_n;
`endif
                  end
               end
               if (m_res == 0 && expired) m_res = 6;
            end
            default: ;
         endcase
      end
      p = m_phase();
      e.st      = 3'(p);
      e.cpu_rst = !(p == 3 || p == 4);
      e.status  = m_status;
      e.prog    = 8'(m_prog);
      e.pass    = (p == 4);
      e.fail    = (p == 5);
      e.tmo     = (p == 6);
      e.done    = (p >= 4);
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, then record what the edge should produce.
   task automatic step(input bit r, input bit scp, input bit we, input logic [31:0] wd);
      rst = r; scp_ready = scp; status_we = we; status_wdata = wd;
      @(posedge clk);
      model_edge(r, scp, we, wd);
      #1;
   endtask

   task automatic idle(input int n, input bit scp);
      for (int i = 0; i < n; i++) step(0, scp, 0, '0);
   endtask

   task automatic chk_reset_state();
      tests++;
      if (state !== 3'd0 || cpu_rst !== 1'b1 || status !== 32'h0 || progress_cnt !== 8'h0 ||
          done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL reset state st=%0d cpu_rst=%b status=%h prog=%0d dpft=%b%b%b%b",
                  state, cpu_rst, status, progress_cnt, done, pass, fail, timeout);
      end
   endtask

   task automatic chk_expired();
      tests++;
      if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || fail !== 1'b0 ||
          cpu_rst !== 1'b1 || status !== 32'h0 || state !== 3'd6) begin
         fails++;
         $display("FAIL expired wait st=%0d cpu_rst=%b status=%h dpft=%b%b%b%b",
                  state, cpu_rst, status, done, pass, fail, timeout);
      end
   endtask

   task automatic do_reset();
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      chk_reset_state();
   endtask

   task automatic go_run();
      for (int i = 0; i < H + 10 && m_phase() != 3; i++) step(0, 1, 0, '0);
   endtask

   // Idle until the next edge is the timer-expiry edge.
   task automatic to_expiry();
      for (int i = 0; i < T + 5 && (m_n + 1 - m_base) != T; i++) step(0, 1, 0, '0);
   endtask

   // Monitor: one expected snapshot per edge, compared mid-cycle.
   always @(negedge clk) begin
      snap_t e, a;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state, cpu_rst, status, progress_cnt, done, pass, fail, timeout};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL outputs cyc=%0d got st=%0d cpu_rst=%b status=%h prog=%0d dpft=%b%b%b%b expected st=%0d cpu_rst=%b status=%h prog=%0d dpft=%b%b%b%b",
                     cyc, a.st, a.cpu_rst, a.status, a.prog, a.done, a.pass, a.fail, a.tmo,
                     e.st, e.cpu_rst, e.status, e.prog, e.done, e.pass, e.fail, e.tmo);
         end
      end
   end

   initial begin
      m_n = 0; m_s = -1; m_run = -1; m_base = 0; m_res = 0;
      m_idle_done = 0; m_status = '0; m_prog = 0;
      @(posedge clk); #1;

      // Boot walk, writes outside RUN ignored, progress then PASS, later writes ignored
      do_reset();
      idle(2, 0);
      step(0, 0, 1, 32'h1234_5678);
      idle(1, 0);
      step(0, 1, 0, '0);
      step(0, 0, 1, 32'h0000_0009);
      go_run();
      step(0, 1, 1, 32'h0000_0001);
      idle(3, 1);
      step(0, 1, 1, PC);
      idle(2, 1);
      step(0, 1, 1, 32'h55);
      step(0, 1, 1, FC);
      idle(3, 1);

      // FAIL resolution
      do_reset();
      go_run();
      idle(5, 1);
      step(0, 1, 1, FC);
      idle(3, 1);
      step(0, 1, 1, PC);
      idle(2, 1);

      // Timeout with no writes
      do_reset();
      go_run();
      idle(T + 10, 1);
      chk_expired();

      // Periodic non-terminal writes every 40 cycles
      do_reset();
      go_run();
      for (int i = 0; i < 500; i++) begin
         if ((i % 40) == 39) step(0, 1, 1, 32'h2);
         else                step(0, 1, 0, '0);
      end

      // Terminal writes and a non-terminal write on the expiry cycle
      do_reset(); go_run(); to_expiry(); step(0, 1, 1, PC); idle(3, 1);
      do_reset(); go_run(); to_expiry(); step(0, 1, 1, FC); idle(3, 1);
      do_reset(); go_run(); to_expiry(); step(0, 1, 1, 32'h77); idle(3, 1);

      // Reset mid-RUN, including one that aborts a pending write
      do_reset();
      go_run();
      idle(10, 1);
      step(0, 1, 1, 32'h3);
      step(1, 1, 1, PC);
      idle(4, 1);
      go_run();
      step(1, 1, 1, 32'h44);
      idle(3, 0);

      // Randomized runs
      for (int r = 0; r < 20; r++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            bit          rr, ss, ww;
            logic [31:0] d;
            int          k;
            rr = ($urandom_range(0, 199) == 0);
            ss = ($urandom_range(0, 3) != 0);
            ww = ($urandom_range(0, 5) == 0);
            k  = $urandom_range(0, 15);
            d  = (k == 0) ? PC : (k == 1) ? FC : $urandom;
            step(rr, ss, ww, d);
         end
      end

      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
